// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare branch predictor: opcode constants,
// FSM state encoding and saturating-counter helpers.
package gshare_predictor_pkg;

    // Opcode range within an instruction word.
    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_LSB = 0;

    typedef logic [OPCODE_MSB:OPCODE_LSB] opcode_t;

    localparam opcode_t OPC_JAL  = 7'b1101111;
    localparam opcode_t OPC_BR   = 7'b1100011;
    localparam opcode_t OPC_JALR = 7'b1100111;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Weak not-taken: MSB clear, all lower bits set.
    function automatic int unsigned cnt_init_val(input int unsigned cnt_bits);
        return (32'd1 << (cnt_bits - 1)) - 32'd1;
    endfunction

    function automatic int unsigned cnt_max_val(input int unsigned cnt_bits);
        return (32'd1 << cnt_bits) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter_update.sv
// Combinational next value of a CNT_BITS-wide saturating counter: +1 on
// taken, -1 on not-taken, holding at all-ones and zero.
module sat_counter_update
    import gshare_predictor_pkg::*;
#(
    parameter int CNT_BITS = 2
) (
    input  logic [CNT_BITS-1:0] cnt_i,
    input  logic                taken_i,
    output logic [CNT_BITS-1:0] cnt_o
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(cnt_max_val(CNT_BITS));

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        cnt_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != CNT_MAX) cnt_o = cnt_i + CNT_BITS'(1);
        end else if (cnt_i != '0) begin
            cnt_o = cnt_i - CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare branch predictor with speculative/committed history and mispredict
// recovery. Optional JALR target buffer enabled by defining PRED_BTB_EN.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int CNT_BITS     = 2,
    parameter int IDX_BITS     = 8,
    parameter int GHR_BITS     = 8,
    parameter int BTB_IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ready_to_fch,
    input  logic        predict_valid_from_fch,
    input  logic [31:0] predict_pc_from_fch,
    input  logic [31:0] predict_inst_from_fch,
    output logic        predicted_jump_sign_to_fch,
    output logic [31:0] predicted_jump_target_pc_to_fch,
    input  logic        enable_sign_from_rob,
    input  logic [31:0] pc_from_rob,
    input  logic        jump_sign_from_rob,
    input  logic        jalr_commit_from_rob,
    input  logic [31:0] jump_target_pc_from_rob,
    input  logic        mispredict_from_rob
);

    localparam int                  ENTRIES  = 1 << IDX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(cnt_init_val(CNT_BITS));
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(ENTRIES - 1);

    state_e              state_q, state_d;
    logic [IDX_BITS-1:0] sweep_q, sweep_d;
    logic [GHR_BITS-1:0] spec_ghr_q, spec_ghr_d;
    logic [GHR_BITS-1:0] commit_ghr_q, commit_ghr_d;
    logic [CNT_BITS-1:0] table_q [ENTRIES];

    logic                run;
    opcode_t             opcode;
    logic [31:0]         imm_j, imm_b, pc_plus4;
    logic [IDX_BITS-1:0] pred_idx, train_idx;
    logic                pred_msb;
    logic [CNT_BITS-1:0] train_cnt_next;
    logic                unused_rob_pc;

    assign run      = (state_q == ST_RUN);
    assign opcode   = predict_inst_from_fch[OPCODE_MSB:OPCODE_LSB];
    assign imm_j    = {{12{predict_inst_from_fch[31]}}, predict_inst_from_fch[19:12],
                       predict_inst_from_fch[20], predict_inst_from_fch[30:21], 1'b0};
    assign imm_b    = {{20{predict_inst_from_fch[31]}}, predict_inst_from_fch[7],
                       predict_inst_from_fch[30:25], predict_inst_from_fch[11:8], 1'b0};
    assign pc_plus4 = predict_pc_from_fch + 32'd4;

    assign pred_idx  = predict_pc_from_fch[IDX_BITS+1:2] ^ IDX_BITS'(spec_ghr_q);
    assign train_idx = pc_from_rob[IDX_BITS+1:2] ^ IDX_BITS'(commit_ghr_q);
    assign pred_msb  = table_q[pred_idx][CNT_BITS-1];
    assign unused_rob_pc = ^pc_from_rob;

    sat_counter_update #(.CNT_BITS(CNT_BITS)) u_sat (
        .cnt_i   (table_q[train_idx]),
        .taken_i (jump_sign_from_rob),
        .cnt_o   (train_cnt_next)
    );

`ifdef PRED_BTB_EN
    localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
    localparam int TAG_BITS    = 32 - BTB_IDX_BITS - 2;

    logic [BTB_ENTRIES-1:0]  btb_valid_q;
    logic [TAG_BITS-1:0]     btb_tag_q [BTB_ENTRIES];
    logic [31:0]             btb_tgt_q [BTB_ENTRIES];
    logic [BTB_IDX_BITS-1:0] btb_rd_idx, btb_wr_idx;
    logic                    btb_hit, btb_we;

    assign btb_rd_idx = predict_pc_from_fch[BTB_IDX_BITS+1:2];
    assign btb_wr_idx = pc_from_rob[BTB_IDX_BITS+1:2];
    assign btb_we     = run && jalr_commit_from_rob;
    assign btb_hit    = btb_valid_q[btb_rd_idx]
                     && (btb_tag_q[btb_rd_idx] == predict_pc_from_fch[31:BTB_IDX_BITS+2]);

    // NOTE: sequential state is assigned with non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btb_valid_q <= '0;
        end else if (btb_we) begin
            btb_valid_q[btb_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && btb_we) begin
            btb_tag_q[btb_wr_idx] <= pc_from_rob[31:BTB_IDX_BITS+2];
            btb_tgt_q[btb_wr_idx] <= jump_target_pc_from_rob;
        end
    end
`else
    logic                    unused_jalr;
    logic [BTB_IDX_BITS-1:0] unused_btb_idx;
    assign unused_jalr    = ^{jalr_commit_from_rob, jump_target_pc_from_rob};
    assign unused_btb_idx = pc_from_rob[BTB_IDX_BITS+1:2];
`endif

    always_comb begin
        predicted_jump_sign_to_fch      = 1'b0;
        predicted_jump_target_pc_to_fch = pc_plus4;
        if (run) begin
            case (opcode)
                OPC_JAL: begin
                    predicted_jump_sign_to_fch      = 1'b1;
                    predicted_jump_target_pc_to_fch = predict_pc_from_fch + imm_j;
                end
                OPC_BR: begin
                    predicted_jump_sign_to_fch      = pred_msb;
                    predicted_jump_target_pc_to_fch = predict_pc_from_fch + imm_b;
                end
`ifdef PRED_BTB_EN
                OPC_JALR: begin
                    if (btb_hit) begin
                        predicted_jump_sign_to_fch      = 1'b1;
                        predicted_jump_target_pc_to_fch = btb_tgt_q[btb_rd_idx];
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign ready_to_fch = run;

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        spec_ghr_d   = spec_ghr_q;
        commit_ghr_d = commit_ghr_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + IDX_BITS'(1);
                if (sweep_q == LAST_IDX) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (enable_sign_from_rob)
                    commit_ghr_d = (commit_ghr_q << 1) | GHR_BITS'(jump_sign_from_rob);
                // Recovery restores the post-commit history and drops any concurrent shift.
                if (mispredict_from_rob)
                    spec_ghr_d = commit_ghr_d;
                else if (predict_valid_from_fch && opcode == OPC_BR)
                    spec_ghr_d = (spec_ghr_q << 1) | GHR_BITS'(pred_msb);
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            sweep_q      <= '0;
            spec_ghr_q   <= '0;
            commit_ghr_q <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            spec_ghr_q   <= spec_ghr_d;
            commit_ghr_q <= commit_ghr_d;
        end
    end

    // NOTE: the pattern table has no reset; the INIT sweep writes every entry before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (!run)
                table_q[sweep_q] <= CNT_INIT;
            else if (enable_sign_from_rob)
                table_q[train_idx] <= train_cnt_next;
        end
    end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor of the fetch-stage bimodal predictor.
- Uses a gshare pattern table of CNT_BITS saturating counters, indexed by PC XOR global history, with speculative and committed GHR copies and mispredict recovery.
- Produces full target PCs (pc+imm), not raw offsets.
- Sits between the fetcher (combinational lookup) and the ROB (commit-time training).

Parameters:
- CNT_BITS, 2, counter width (>=2)
- IDX_BITS, 8, log2 of pattern-table entries
- GHR_BITS, 8, global history length (1..IDX_BITS)
- BTB_IDX_BITS, 4, log2 of JALR target-buffer entries (used only with PRED_BTB_EN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- ready_to_fch  out  1  table sweep complete; predictions valid
- predict_valid_from_fch  in  1  fetcher consumes this cycle's prediction
- predict_pc_from_fch  in  32  PC of fetched instruction
- predict_inst_from_fch  in  32  fetched instruction
- predicted_jump_sign_to_fch  out  1  predicted taken
- predicted_jump_target_pc_to_fch  out  32  predicted target (full PC)
- enable_sign_from_rob  in  1  conditional branch committed
- pc_from_rob  in  32  PC of committed branch/JALR
- jump_sign_from_rob  in  1  actual direction
- jalr_commit_from_rob  in  1  JALR committed
- jump_target_pc_from_rob  in  32  actual JALR target
- mispredict_from_rob  in  1  committed instruction mispredicted; pipeline flushed

Behaviour:
- Index: idx = pc[IDX_BITS+1:2] XOR zero-extended GHR.
  - Lookup uses spec_ghr.
  - Training uses commit_ghr, which equals the predict-time history along the correct path.
- Counter init value: 2^(CNT_BITS-1)-1 (weak not-taken).
- Taken prediction = counter MSB.
- Training: saturating +1 on taken, -1 on not-taken. Counter holds at all-ones or zero.
- FSM, two states, INIT and RUN:
  - rst low: state<=INIT, sweep_idx<=0, spec_ghr<=0, commit_ghr<=0, BTB valid bits<=0.
  - INIT: write init value to table[sweep_idx], one entry per cycle. After entry 2^IDX_BITS-1, go to RUN, so INIT lasts 2^IDX_BITS cycles.
  - Reset mid-sweep or mid-run restarts INIT from index 0.
- Outputs in INIT: ready_to_fch=0, predicted_jump_sign_to_fch=0, target=pc+4. All fetch and ROB inputs are ignored.
- Outputs in RUN: ready_to_fch=1. Prediction is combinational, zero latency:
  - JAL: sign 1, target pc+J-imm.
  - BRANCH: sign = counter MSB, target pc+B-imm.
  - JALR: sign 0, target pc+4 (see optional feature).
  - Any other opcode: sign 0, target pc+4.
- spec_ghr:
  - On predict_valid_from_fch & RUN & BRANCH opcode: spec_ghr <= {spec_ghr[GHR_BITS-2:0], predicted sign}.
  - Mispredict recovery overrides this shift in the same cycle.
- commit_ghr: on enable_sign_from_rob, commit_ghr <= {commit_ghr[GHR_BITS-2:0], jump_sign_from_rob}.
- Mispredict recovery: spec_ghr <= the commit_ghr value after this cycle's commit shift.
  - If enable is also high, the restored history includes the actual outcome.
  - If enable is low (JALR mispredict), the restored history is the unshifted commit_ghr.
- Same-cycle training and lookup to the same index: lookup sees the pre-update counter. No bypass.
- Address arithmetic wraps mod 2^32.

Optional Feature:
- Macro: PRED_BTB_EN
- With the macro: direct-mapped JALR BTB of 2^BTB_IDX_BITS entries, each holding {valid, tag=pc[31:BTB_IDX_BITS+2], target}.
  - Lookup for JALR: hit gives sign 1 and the stored target; miss gives sign 0 and pc+4.
  - jalr_commit_from_rob in RUN writes valid=1, tag and jump_target_pc_from_rob.
  - A write in the same cycle as a lookup to the same entry is visible next cycle.
- Without the macro: no BTB storage; JALR always predicts sign 0, target pc+4; jalr_commit_from_rob is ignored.

Decomposition:
- Shared defines package: opcode constants (JAL, BR, JALR), OPCODE_RANGE, counter init/saturate helpers expressed from CNT_BITS, FSM state encodings.
- One sub-module, sat_counter_update: combinational next-value of a CNT_BITS saturating counter given the taken bit.
- Immediate decode stays inline.

Test Plan:
- Reset, then 256 cycles -> ready_to_fch=0 and sign=0 throughout INIT; ready_to_fch=1 on cycle 257.
- RUN, BR at pc 0x100 with B-imm 0x20, fresh table -> sign 0, target 0x120. Then train taken at that index (commit_ghr=0) 2x -> lookup with spec_ghr=0 gives sign 1.
- 5x taken commits, CNT_BITS=2, one index -> counter saturates at 3; one not-taken -> 2, MSB still 1.
- 3 speculative taken predictions, then mispredict+enable with actual 0 while commit_ghr=0 -> spec_ghr=0 next cycle; the concurrent predict shift is dropped.
- JAL at 0xFFFFFFF0 with imm +0x20 -> sign 1, target 0x00000010 (wrap).
- PRED_BTB_EN: jalr_commit pc 0x200 target 0x4000 -> next-cycle JALR lookup at 0x200 gives sign 1, target 0x4000. Lookup at 0x200+(4<<BTB_IDX_BITS) (tag miss) gives sign 0.
